// File: rtl/mem_wb_stage_if.sv
// ----------------------------------------------------------------------------
// mem_wb_stage_if
//   Data-memory request/response port used by the memory/write-back stage.
//   One request is outstanding at a time; it completes in the cycle where
//   dmem_valid and dmem_ready are both high.
//
//   dmem_valid  master->slave  request valid
//   dmem_ready  slave->master  memory accepts/completes the request
//   dmem_addr   master->slave  word-aligned address
//   dmem_wstrb  master->slave  byte strobes, 4'b0000 means read
//   dmem_wdata  master->slave  store data, replicated across byte lanes
//   dmem_rdata  slave->master  read data, valid in the dmem_ready cycle
// ----------------------------------------------------------------------------
interface mem_wb_stage_if;
    logic        dmem_valid;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_valid,
        output dmem_addr,
        output dmem_wstrb,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_valid,
        input  dmem_addr,
        input  dmem_wstrb,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
//   Memory / write-back stage that sits directly after execute. Non-memory
//   instructions retire in one cycle. Loads and stores issue one request on
//   the dmem port and stall execute until the memory answers. Misaligned
//   accesses, illegal sizes and bus timeouts put the stage into a terminal
//   exception state that only reset leaves.
//
//   clk, resetb    clock (rising edge) and asynchronous active-low reset
//   ex_*           retiring instruction from execute; ex_stall holds execute
//   dmem           data-memory request port (master side)
//   wb_en/dst/data register-file write port, wb_en is a one-cycle pulse
//   wb_exception   sticky fault flag, wb_exc_addr the faulting address
// ----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              ex_valid,
    output logic              ex_stall,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_store_data,
    input  logic              ex_memwr,
    input  logic              ex_mem2reg,
    input  logic [2:0]        ex_subtype,
    input  logic              ex_wben,
    input  logic [4:0]        ex_dst_sel,
    mem_wb_stage_if.master    dmem,
    output logic              wb_en,
    output logic [4:0]        wb_dst,
    output logic [31:0]       wb_data,
    output logic              wb_exception,
    output logic [31:0]       wb_exc_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_EXC  = 2'd2
    } state_t;

    // Last counter value that still waits; one more idle cycle is a bus error.
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);

    // Misalignment or an encoding that has no legal access size.
    function automatic logic access_fault(input logic [1:0] a, input logic wr,
                                          input logic rd, input logic [2:0] sub);
        logic f;
        f = 1'b0;
        case (sub)
            3'b000:  f = 1'b0;
            3'b001:  f = a[0];
            3'b010:  f = (a != 2'b00);
            3'b100:  f = wr;
            3'b101:  f = wr | a[0];
            default: f = 1'b1;
        endcase
        return f | (wr & rd);
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] a, input logic [1:0] size);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = 4'b0011 << a;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data is replicated so the memory can pick any lane by strobe.
    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic [2:0] sub);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {a, 3'b000};
        case (sub)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'h000000, s[7:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t            state_r,    state_nx_s;
    logic              valid_r,    valid_nx_s;
    logic [29:0]       addr_r,     addr_nx_s;
    logic [3:0]        wstrb_r,    wstrb_nx_s;
    logic [31:0]       wdata_r,    wdata_nx_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_nx_s;
    logic [4:0]        rd_r,       rd_nx_s;
    logic [2:0]        sub_r,      sub_nx_s;
    logic              load_r,     load_nx_s;
    logic [31:0]       eff_r,      eff_nx_s;
    logic              wb_en_r,    wb_en_nx_s;
    logic [4:0]        wb_dst_r,   wb_dst_nx_s;
    logic [31:0]       wb_data_r,  wb_data_nx_s;
    logic              exc_r,      exc_nx_s;
    logic [31:0]       exc_addr_r, exc_addr_nx_s;

    logic is_mem_s;
    logic fault_s;

    assign is_mem_s = ex_memwr | ex_mem2reg;
    assign fault_s  = access_fault(ex_result[1:0], ex_memwr, ex_mem2reg, ex_subtype);

    assign ex_stall        = (state_r != ST_IDLE);
    assign dmem.dmem_valid = valid_r;
    assign dmem.dmem_addr  = {addr_r, 2'b00};
    assign dmem.dmem_wstrb = wstrb_r;
    assign dmem.dmem_wdata = wdata_r;
    assign wb_en           = wb_en_r;
    assign wb_dst          = wb_dst_r;
    assign wb_data         = wb_data_r;
    assign wb_exception    = exc_r;
    assign wb_exc_addr     = exc_addr_r;

    // Next-state and next-output logic for the IDLE/MEM/EXC controller.
    always_comb begin
        state_nx_s    = state_r;
        valid_nx_s    = valid_r;
        addr_nx_s     = addr_r;
        wstrb_nx_s    = wstrb_r;
        wdata_nx_s    = wdata_r;
        cnt_nx_s      = cnt_r;
        rd_nx_s       = rd_r;
        sub_nx_s      = sub_r;
        load_nx_s     = load_r;
        eff_nx_s      = eff_r;
        wb_en_nx_s    = 1'b0;
        wb_dst_nx_s   = wb_dst_r;
        wb_data_nx_s  = wb_data_r;
        exc_nx_s      = exc_r;
        exc_addr_nx_s = exc_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_mem_s) begin
                        if (fault_s) begin
                            state_nx_s    = ST_EXC;
                            exc_nx_s      = 1'b1;
                            exc_addr_nx_s = ex_result;
                        end else begin
                            state_nx_s = ST_MEM;
                            valid_nx_s = 1'b1;
                            addr_nx_s  = ex_result[31:2];
                            wstrb_nx_s = ex_memwr ? store_strobe(ex_result[1:0], ex_subtype[1:0])
                                                  : 4'b0000;
                            wdata_nx_s = store_data(ex_store_data, ex_subtype[1:0]);
                            cnt_nx_s   = {CNT_W{1'b0}};
                            rd_nx_s    = ex_dst_sel;
                            sub_nx_s   = ex_subtype;
                            load_nx_s  = ex_mem2reg;
                            eff_nx_s   = ex_result;
                        end
                    end else begin
                        wb_en_nx_s   = ex_wben & (ex_dst_sel != 5'd0);
                        wb_dst_nx_s  = ex_dst_sel;
                        wb_data_nx_s = ex_result;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (dmem.dmem_ready) begin
                    state_nx_s = ST_IDLE;
                    valid_nx_s = 1'b0;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    if (load_r) begin
                        wb_en_nx_s   = (rd_r != 5'd0);
                        wb_dst_nx_s  = rd_r;
                        wb_data_nx_s = load_align(dmem.dmem_rdata, eff_r[1:0], sub_r);
                    end else begin
                        wb_en_nx_s = 1'b0;
                    end
                end else if (cnt_r == TIMEOUT_CNT) begin
                    // Bus error: the request has waited TIMEOUT cycles.
                    state_nx_s    = ST_EXC;
                    valid_nx_s    = 1'b0;
                    cnt_nx_s      = {CNT_W{1'b0}};
                    exc_nx_s      = 1'b1;
                    exc_addr_nx_s = eff_r;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_EXC: begin
                valid_nx_s = 1'b0;
                exc_nx_s   = 1'b1;
            end
            default: begin
                // Unreachable encoding: fail safe into the fault state.
                state_nx_s = ST_EXC;
                valid_nx_s = 1'b0;
                exc_nx_s   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r    <= ST_IDLE;
            valid_r    <= 1'b0;
            addr_r     <= 30'd0;
            wstrb_r    <= 4'b0000;
            wdata_r    <= 32'h0000_0000;
            cnt_r      <= {CNT_W{1'b0}};
            rd_r       <= 5'd0;
            sub_r      <= 3'b000;
            load_r     <= 1'b0;
            eff_r      <= 32'h0000_0000;
            wb_en_r    <= 1'b0;
            wb_dst_r   <= 5'd0;
            wb_data_r  <= 32'h0000_0000;
            exc_r      <= 1'b0;
            exc_addr_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_nx_s;
            valid_r    <= valid_nx_s;
            addr_r     <= addr_nx_s;
            wstrb_r    <= wstrb_nx_s;
            wdata_r    <= wdata_nx_s;
            cnt_r      <= cnt_nx_s;
            rd_r       <= rd_nx_s;
            sub_r      <= sub_nx_s;
            load_r     <= load_nx_s;
            eff_r      <= eff_nx_s;
            wb_en_r    <= wb_en_nx_s;
            wb_dst_r   <= wb_dst_nx_s;
            wb_data_r  <= wb_data_nx_s;
            exc_r      <= exc_nx_s;
            exc_addr_r <= exc_addr_nx_s;
        end
    end

endmodule
